// File: rtl/spi_arb_if.sv
// rtl/spi_arb_if.sv - requester and SPI monarch signal bundle for spi_arb
interface spi_arb_if;
  logic        req0;
  logic [15:0] cmd0;
  logic        gnt0;
  logic        done0;
  logic [15:0] resp0;
  logic        req1;
  logic [15:0] cmd1;
  logic        gnt1;
  logic        done1;
  logic [15:0] resp1;
  logic        spi_snd;
  logic [15:0] spi_cmd;
  logic        spi_done;
  logic [15:0] spi_resp;
  logic        busy;
  logic        tmo;

  modport slave (
    input  req0, cmd0, req1, cmd1, spi_done, spi_resp,
    output gnt0, done0, resp0, gnt1, done1, resp1, spi_snd, spi_cmd, busy, tmo
  );

  modport master (
    output req0, cmd0, req1, cmd1, spi_done, spi_resp,
    input  gnt0, done0, resp0, gnt1, done1, resp1, spi_snd, spi_cmd, busy, tmo
  );
endinterface

// File: rtl/spi_arb.sv
// rtl/spi_arb.sv - round-robin sharing of one SPI monarch between two requesters
module spi_arb #(
  parameter int GAP_CLKS = 4,
  parameter int TMO_CLKS = 4096
) (
  input logic      clk,
  input logic      rst,
  spi_arb_if.slave bus
);

  localparam int TW = (TMO_CLKS > 1) ? $clog2(TMO_CLKS) : 1;
  localparam int GW = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CLKS - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CLKS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_BUSY,
    S_GAP
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   cmd_q, cmd_d;
  logic          owner_q, owner_d;
  logic          last_owner_q, last_owner_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [15:0]   resp0_q, resp0_d;
  logic [15:0]   resp1_q, resp1_d;
  logic          done0_q, done0_d;
  logic          done1_q, done1_d;
  logic          tmo_q, tmo_d;
  logic          gnt0, gnt1;
  logic          pick;
  logic          finish;
  logic          abort;
  logic [15:0]   fin_resp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cmd_q        <= '0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      tmo_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      resp0_q      <= '0;
      resp1_q      <= '0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      tmo_cnt_q    <= tmo_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      resp0_q      <= resp0_d;
      resp1_q      <= resp1_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      tmo_q        <= tmo_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    tmo_cnt_d    = tmo_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    resp0_d      = resp0_q;
    resp1_d      = resp1_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    tmo_d        = 1'b0;
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    pick         = 1'b0;
    finish       = 1'b0;
    abort        = 1'b0;
    fin_resp     = '0;

    case (state_q)
      S_IDLE: begin
        // On a tie the requester that did not own the last transaction wins.
        pick = (bus.req0 && bus.req1) ? ~last_owner_q : bus.req1;
        if (bus.req0 || bus.req1) begin
          gnt0         = ~pick;
          gnt1         = pick;
          cmd_d        = pick ? bus.cmd1 : bus.cmd0;
          owner_d      = pick;
          last_owner_d = pick;
          state_d      = S_SEND;
        end
      end
      S_SEND: begin
        tmo_cnt_d = '0;
        state_d   = S_BUSY;
      end
      S_BUSY: begin
        if (bus.spi_done) begin
          finish   = 1'b1;
          fin_resp = bus.spi_resp;
        end else if (tmo_cnt_q == TMO_LAST) begin
          finish   = 1'b1;
          abort    = 1'b1;
          fin_resp = 16'hFFFF;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Only the owner's response register is touched; done lands with it.
    if (finish) begin
      if (owner_q) begin
        resp1_d = fin_resp;
        done1_d = 1'b1;
      end else begin
        resp0_d = fin_resp;
        done0_d = 1'b1;
      end
      tmo_d     = abort;
      gap_cnt_d = '0;
      state_d   = S_GAP;
    end
  end

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.done0   = done0_q;
  assign bus.done1   = done1_q;
  assign bus.resp0   = resp0_q;
  assign bus.resp1   = resp1_q;
  assign bus.tmo     = tmo_q;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.spi_snd = (state_q == S_SEND);
  assign bus.spi_cmd = (state_q == S_SEND || state_q == S_BUSY) ? cmd_q : '0;

endmodule

// File: tb/tb_spi_arb.sv
// tb/tb_spi_arb.sv - scoreboard bench for spi_arb with a behavioural SPI monarch
module tb_spi_arb;
  localparam int GAP = 4;
  localparam int TMO = 64;

  typedef struct packed {
    logic        port;
    logic [15:0] cmd;
  } gnt_t;

  typedef struct packed {
    logic        port;
    logic [15:0] resp;
    logic        tmo;
  } done_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  spi_arb_if bus ();

  spi_arb #(.GAP_CLKS(GAP), .TMO_CLKS(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  gnt_t        exp_gnt_q[$];
  done_t       exp_done_q[$];
  logic [15:0] rsp_q[$];
  int          spi_lat = 0;

  int          cyc = 0;
  int          gnt_cnt[2] = '{0, 0};
  int          done_cnt = 0;
  int          snd_cyc_q[$];
  int          last_snd_cyc = 0;
  int          last_gnt_cyc = 0;
  int          last_done_cyc = 0;
  int          last_tmo_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // SPI monarch: done clears on the edge that takes snd, rises spi_lat clocks later.
  initial begin
    logic        s;
    logic        r;
    int          cnt;
    cnt          = 0;
    bus.spi_done = 1'b0;
    bus.spi_resp = '0;
    forever begin
      @(negedge clk);
      s = bus.spi_snd;
      r = rst;
      @(posedge clk);
      #1;
      if (r) begin
        bus.spi_done = 1'b0;
        cnt          = 0;
      end else if (s) begin
        bus.spi_done = 1'b0;
        cnt          = spi_lat;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.spi_done = 1'b1;
          bus.spi_resp = (rsp_q.size() > 0) ? rsp_q.pop_front() : 16'hDEAD;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the arbiter presents a grant, launch or completion.
  initial begin
    logic        snd_due;
    logic [15:0] due_cmd;
    logic        prev_spi_done;
    logic [15:0] mdl_resp[2];
    gnt_t        g;
    done_t       d;
    snd_due       = 1'b0;
    due_cmd       = '0;
    prev_spi_done = 1'b0;
    mdl_resp[0]   = '0;
    mdl_resp[1]   = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        mdl_resp[0] = '0;
        mdl_resp[1] = '0;
        snd_due     = 1'b0;
      end
      if (snd_due || bus.spi_snd) begin
        chk("snd_after_gnt", {31'd0, bus.spi_snd}, {31'd0, snd_due});
        if (snd_due) chk("spi_cmd", {16'd0, bus.spi_cmd}, {16'd0, due_cmd});
        if (bus.spi_snd) begin
          last_snd_cyc = cyc;
          snd_cyc_q.push_back(cyc);
        end
      end
      snd_due = 1'b0;
      if (bus.gnt0 || bus.gnt1) begin
        last_gnt_cyc = cyc;
        if (bus.gnt1) gnt_cnt[1]++;
        else gnt_cnt[0]++;
        if (exp_gnt_q.size() == 0) begin
          chk("gnt_unexpected", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
        end else begin
          g = exp_gnt_q.pop_front();
          chk("gnt_port", {30'd0, bus.gnt1, bus.gnt0}, g.port ? 32'd2 : 32'd1);
          due_cmd = g.cmd;
          snd_due = 1'b1;
        end
      end
      if (bus.done0 || bus.done1 || bus.tmo) begin
        last_done_cyc = cyc;
        done_cnt++;
        if (bus.tmo) last_tmo_cyc = cyc;
        if (exp_done_q.size() == 0) begin
          chk("done_unexpected", {29'd0, bus.tmo, bus.done1, bus.done0}, 32'd0);
        end else begin
          d = exp_done_q.pop_front();
          mdl_resp[d.port] = d.resp;
          chk("done_port", {30'd0, bus.done1, bus.done0}, d.port ? 32'd2 : 32'd1);
          chk("tmo_flag", {31'd0, bus.tmo}, {31'd0, d.tmo});
          chk("resp_owner", {16'd0, d.port ? bus.resp1 : bus.resp0}, {16'd0, d.resp});
          chk("resp_other", {16'd0, d.port ? bus.resp0 : bus.resp1}, {16'd0, mdl_resp[!d.port]});
          if (!d.tmo) chk("done_after_spi_done", {31'd0, prev_spi_done}, 32'd1);
        end
      end
      prev_spi_done = bus.spi_done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sync_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic push_txn(input logic port, input logic [15:0] cmd, input logic [15:0] resp,
                          input logic timeout);
    exp_gnt_q.push_back('{port, cmd});
    exp_done_q.push_back('{port, resp, timeout});
    if (!timeout) rsp_q.push_back(resp);
  endtask

  task automatic request(input logic port, input logic [15:0] cmd, output int waited);
    int base;
    base   = gnt_cnt[port];
    waited = 0;
    if (port) begin
      bus.req1 = 1'b1;
      bus.cmd1 = cmd;
    end else begin
      bus.req0 = 1'b1;
      bus.cmd0 = cmd;
    end
    sync_neg();
    while (gnt_cnt[port] == base && waited < 400) begin
      waited++;
      sync_neg();
    end
    if (gnt_cnt[port] == base) chk("gnt_timeout", 32'd0, 32'd1);
    tick();
    if (port) bus.req1 = 1'b0;
    else bus.req0 = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    sync_neg();
    while (done_cnt < target && k < 400) begin
      k++;
      sync_neg();
    end
    if (done_cnt < target) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    sync_neg();
    while (bus.busy && k < 400) begin
      k++;
      sync_neg();
    end
    if (bus.busy) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int w;
    int base;
    int g1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.cmd0 = '0;
    bus.cmd1 = '0;
    rst      = 1'b1;
    repeat (3) tick();
    sync_neg();
    chk("rst_outputs", {25'd0, bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.spi_snd,
                        bus.busy, bus.tmo}, 32'd0);
    chk("rst_resp", {bus.resp1, bus.resp0}, 32'd0);
    chk("rst_spi_cmd", {16'd0, bus.spi_cmd}, 32'd0);
    tick();
    rst = 1'b0;

    // Single requester 0 transaction, 40-clock transfer.
    tick();
    spi_lat = 40;
    push_txn(1'b0, 16'hA65A, 16'h00C3, 1'b0);
    request(1'b0, 16'hA65A, w);
    chk("t1_gnt_same_cycle", w, 32'd0);
    wait_done(1);
    chk("t1_snd_next_cycle", last_snd_cyc - last_gnt_cyc, 32'd1);
    chk("t1_done_latency", last_done_cyc - last_snd_cyc, 32'd42);
    chk("t1_resp1_clear", {16'd0, bus.resp1}, 32'd0);
    wait_idle();

    // Both requesters held high after reset: grants 0, 1, 0.
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    spi_lat = 10;
    push_txn(1'b0, 16'h0A01, 16'h1111, 1'b0);
    push_txn(1'b1, 16'h1B02, 16'h2222, 1'b0);
    push_txn(1'b0, 16'h0A01, 16'h3333, 1'b0);
    base = snd_cyc_q.size();
    g1   = gnt_cnt[0] + gnt_cnt[1];
    bus.cmd0 = 16'h0A01;
    bus.cmd1 = 16'h1B02;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    w = 0;
    sync_neg();
    while (gnt_cnt[0] + gnt_cnt[1] < g1 + 3 && w < 400) begin
      w++;
      sync_neg();
    end
    chk("t2_three_grants", gnt_cnt[0] + gnt_cnt[1] - g1, 32'd3);
    tick();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    wait_done(4);
    if (snd_cyc_q.size() >= base + 3) begin
      chk("t2_spacing_a", snd_cyc_q[base+1] - snd_cyc_q[base], 10 + GAP + 3);
      chk("t2_spacing_b", snd_cyc_q[base+2] - snd_cyc_q[base+1], 10 + GAP + 3);
    end else begin
      chk("t2_snd_count", snd_cyc_q.size() - base, 32'd3);
    end
    wait_idle();

    // Requester 1 owns the bus; requester 0 arrives mid-transfer and waits out the gap.
    tick();
    spi_lat = 20;
    push_txn(1'b1, 16'h1160, 16'h5A5A, 1'b0);
    request(1'b1, 16'h1160, w);
    repeat (5) tick();
    push_txn(1'b0, 16'h0C0C, 16'h7E7E, 1'b0);
    request(1'b0, 16'h0C0C, w);
    chk("t3_gnt0_after_gap", last_gnt_cyc - last_done_cyc, GAP);
    wait_done(6);
    chk("t3_resp1_kept", {16'd0, bus.resp1}, 32'h5A5A);
    wait_idle();

    // Watchdog: spi_done never rises.
    tick();
    spi_lat = 0;
    push_txn(1'b0, 16'h2222, 16'hFFFF, 1'b1);
    request(1'b0, 16'h2222, w);
    wait_done(7);
    chk("t4_tmo_latency", last_tmo_cyc - last_snd_cyc, TMO + 1);
    chk("t4_tmo_with_done", last_tmo_cyc, last_done_cyc);
    wait_idle();
    chk("t4_gap_to_idle", cyc - last_done_cyc, GAP);

    // Reset mid-transfer aborts silently.
    tick();
    spi_lat = 30;
    exp_gnt_q.push_back('{1'b0, 16'h3333});
    request(1'b0, 16'h3333, w);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sync_neg();
    chk("t5_after_rst", {27'd0, bus.busy, bus.done0, bus.done1, bus.tmo, bus.spi_snd}, 32'd0);
    chk("t5_resp0_rst", {16'd0, bus.resp0}, 32'd0);
    repeat (40) tick();
    chk("t5_no_done", done_cnt, 32'd7);
    spi_lat = 8;
    push_txn(1'b0, 16'h4444, 16'h0F0F, 1'b0);
    request(1'b0, 16'h4444, w);
    chk("t5_regrant", w, 32'd0);
    wait_done(8);
    wait_idle();

    // A one-cycle req1 during GAP is never granted.
    tick();
    spi_lat = 5;
    push_txn(1'b0, 16'h5555, 16'h6060, 1'b0);
    request(1'b0, 16'h5555, w);
    wait_done(9);
    g1 = gnt_cnt[1];
    tick();
    bus.req1 = 1'b1;
    bus.cmd1 = 16'hBEEF;
    tick();
    bus.req1 = 1'b0;
    repeat (15) tick();
    chk("t6_no_gnt1", gnt_cnt[1], g1);
    chk("t6_idle", {31'd0, bus.busy}, 32'd0);

    chk("sb_gnt_drained", exp_gnt_q.size(), 32'd0);
    chk("sb_done_drained", exp_done_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
